// File: rtl/ascii_value_formatter.sv
// ascii_value_formatter
// Converts a 14-bit value into a four-character decimal ASCII string.
// The conversion is an iterative double-dabble, one bit per clock. The
// result is presented on a registered 32-bit bus together with a one-cycle
// load strobe. Character 0, the leftmost on screen, is string_out[31:24].
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; captures value and mode bits
// S_CONVERT| one double-dabble step per clock, IN_WIDTH steps in total
// S_FORMAT | builds the ASCII string, pulses load_string, returns idle
module ascii_value_formatter #(
  parameter int IN_WIDTH = 14
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                start,
  input  logic [IN_WIDTH-1:0] value_in,
  input  logic                signed_mode,
  input  logic                blank_zeros,
  output logic                busy,
  output logic [31:0]         string_out,
  output logic                load_string
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_FORMAT  = 2'd2
  } state_t;

  localparam logic [31:0] STR_SPACES = 32'h20202020;
  localparam logic [31:0] STR_OVFL   = 32'h4F56464C;
  localparam logic [3:0]  STEP_LAST  = 4'(IN_WIDTH - 1);

  state_t                state_q, state_d;
  logic [IN_WIDTH-1:0]   mag_q, mag_d;
  logic [15:0]           bcd_q, bcd_d;
  logic [3:0]            step_q, step_d;
  logic                  neg_q, neg_d;
  logic                  ovf_q, ovf_d;
  logic                  blank_q, blank_d;
  logic [31:0]           string_q, string_d;
  logic                  load_q, load_d;

  logic                  cap_neg;
  logic [IN_WIDTH-1:0]   cap_mag;
  logic                  cap_ovf;
  logic [15:0]           bcd_adj;
  logic [15+IN_WIDTH:0]  shift_w;
  logic [3:0]            dig [4];
  logic [2:0]            lead;
  logic [31:0]           fmt_str;

  // Sign, magnitude and range of the incoming value, evaluated at capture.
  // The magnitude of -8192 is 8192, which fits the unsigned 14-bit field.
  always_comb begin
    cap_neg = signed_mode & value_in[IN_WIDTH-1];
    cap_mag = cap_neg ? (~value_in + IN_WIDTH'(1)) : value_in;
    cap_ovf = cap_neg ? (cap_mag > IN_WIDTH'(999)) : (cap_mag > IN_WIDTH'(9999));
  end

  // One double-dabble step: add 3 to every nibble >= 5, then shift the
  // magnitude MSB into the BCD register. Digits beyond four fall off the
  // top; those values are already flagged as overflow.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? (bcd_q[4*i +: 4] + 4'd3)
                                                     : bcd_q[4*i +: 4];
    end
    shift_w = {bcd_adj, mag_q} << 1;
  end

  // Split the BCD register into digits, dig[0] being the most significant.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      dig[p] = bcd_q[15-4*p -: 4];
    end
  end

  // Number of leading positions to blank. For negative values the digit
  // field starts at position 1, and the minus sign takes the last of the
  // blanked positions, so the same count also places the sign.
  always_comb begin
    lead = 3'd0;
    if (blank_q) begin
      if (neg_q) begin
        if (dig[1] != 4'd0)      lead = 3'd0;
        else if (dig[2] != 4'd0) lead = 3'd1;
        else                     lead = 3'd2;
      end else begin
        if (dig[0] != 4'd0)      lead = 3'd0;
        else if (dig[1] != 4'd0) lead = 3'd1;
        else if (dig[2] != 4'd0) lead = 3'd2;
        else                     lead = 3'd3;
      end
    end
  end

  // ASCII assembly: spaces left of the lead count, then the sign (negative
  // only), then digits. Character 3 is never blanked because lead <= 3 for
  // positive values and the sign never lands past position 2.
  always_comb begin
    fmt_str = STR_SPACES;
    for (int p = 0; p < 4; p++) begin
      if (3'(p) < lead) begin
        fmt_str[31-8*p -: 8] = 8'h20;
      end else if (neg_q && (3'(p) == lead)) begin
        fmt_str[31-8*p -: 8] = 8'h2D;
      end else begin
        fmt_str[31-8*p -: 8] = 8'h30 + {4'h0, dig[p]};
      end
    end
  end

  // Next-state and datapath control for the conversion sequence.
  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    bcd_d    = bcd_q;
    step_d   = step_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    blank_d  = blank_q;
    string_d = string_q;
    load_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mag_d   = cap_mag;
          neg_d   = cap_neg;
          ovf_d   = cap_ovf;
          blank_d = blank_zeros;
          bcd_d   = 16'h0000;
          step_d  = STEP_LAST;
          state_d = S_CONVERT;
        end
      end

      S_CONVERT: begin
        bcd_d = shift_w[15+IN_WIDTH:IN_WIDTH];
        mag_d = shift_w[IN_WIDTH-1:0];
        if (step_q == 4'd0) begin
          state_d = S_FORMAT;
        end else begin
          step_d = step_q - 4'd1;
        end
      end

      S_FORMAT: begin
        string_d = ovf_q ? STR_OVFL : fmt_str;
        load_d   = 1'b1;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      mag_q    <= '0;
      bcd_q    <= 16'h0000;
      step_q   <= 4'd0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      blank_q  <= 1'b0;
      string_q <= STR_SPACES;
      load_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      bcd_q    <= bcd_d;
      step_q   <= step_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      blank_q  <= blank_d;
      string_q <= string_d;
      load_q   <= load_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign string_out  = string_q;
  assign load_string = load_q;

endmodule

// File: tb/tb_ascii_value_formatter.sv
// Bench for ascii_value_formatter: a cycle-level protocol model plus a
// decimal-arithmetic formatter, checked every cycle, and directed vectors
// with literal expected strings.
module tb_ascii_value_formatter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start;
  logic [13:0] value_in;
  logic        signed_mode;
  logic        blank_zeros;
  logic        busy;
  logic [31:0] string_out;
  logic        load_string;

  int n_checks = 0;
  int n_fail   = 0;

  ascii_value_formatter #(.IN_WIDTH(14)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .start       (start),
    .value_in    (value_in),
    .signed_mode (signed_mode),
    .blank_zeros (blank_zeros),
    .busy        (busy),
    .string_out  (string_out),
    .load_string (load_string)
  );

  always #5 Clk = ~Clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Formatting rules expressed with plain decimal arithmetic.
  function automatic logic [31:0] fmt(input logic [13:0] v, input logic sm, input logic bz);
    int val, mag, ndig, t, pw, d, r;
    logic [31:0] s;
    val = int'(v);
    if (sm && v[13]) val = val - 16384;
    mag = (val < 0) ? -val : val;
    if ((val < 0 && mag > 999) || (val >= 0 && mag > 9999)) return 32'h4F56464C;
    ndig = 1;
    t = mag;
    while (t >= 10) begin t = t / 10; ndig++; end
    s = 32'h20202020;
    for (int p = 0; p < 4; p++) begin
      r = 3 - p;
      pw = 1;
      for (int k = 0; k < r; k++) pw = pw * 10;
      d = (mag / pw) % 10;
      if (val >= 0) begin
        if (bz && r >= ndig) s[31-8*p -: 8] = 8'h20;
        else                 s[31-8*p -: 8] = 8'(48 + d);
      end else if (!bz) begin
        s[31-8*p -: 8] = (p == 0) ? 8'h2D : 8'(48 + d);
      end else begin
        if (r < ndig)       s[31-8*p -: 8] = 8'(48 + d);
        else if (r == ndig) s[31-8*p -: 8] = 8'h2D;
        else                s[31-8*p -: 8] = 8'h20;
      end
    end
    return s;
  endfunction

  // Protocol model: a result appears 15 edges after an accepted start;
  // start is only seen when no result is pending.
  int          m_cnt = 0;
  logic [31:0] m_str = 32'h20202020;
  logic [31:0] m_pend = 32'h0;
  logic        m_load = 1'b0;
  bit          chk_en = 1'b0;

  always @(posedge Clk) begin
    if (Reset) begin
      m_cnt  = 0;
      m_str  = 32'h20202020;
      m_load = 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_str  = m_pend;
        m_load = 1'b1;
      end
    end else begin
      m_load = 1'b0;
      if (start) begin
        m_pend = fmt(value_in, signed_mode, blank_zeros);
        m_cnt  = 15;
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      check_int("busy", int'(busy), int'(m_cnt != 0));
      check_int("load_string", int'(load_string), int'(m_load));
      check32("string_out", string_out, m_str);
    end
  end

  // One conversion with a literal expected string, busy-width and latency.
  task automatic convert(input string name, input logic [13:0] v, input logic sm,
                         input logic bz, input logic [31:0] exp);
    int i, busy_cyc;
    bit got;
    @(posedge Clk); #2;
    value_in = v; signed_mode = sm; blank_zeros = bz; start = 1'b1;
    @(posedge Clk); #2;
    start = 1'b0; value_in = ~v; signed_mode = ~sm; blank_zeros = ~bz;
    got = 0; busy_cyc = 0; i = 0;
    while (!got && i < 30) begin
      @(negedge Clk);
      i++;
      if (busy) busy_cyc++;
      if (load_string) got = 1;
    end
    check_int({name, "_strobe_seen"}, int'(got), 1);
    if (got) begin
      check32(name, string_out, exp);
      check_int({name, "_latency"}, i, 16);
      check_int({name, "_busy_cycles"}, busy_cyc, 15);
      check_int({name, "_busy_at_strobe"}, int'(busy), 0);
    end
  endtask

  task automatic count_strobes(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge Clk);
      if (load_string) n++;
    end
  endtask

  initial begin
    int n, i;
    bit got;
    Reset = 1'b1; start = 1'b0; value_in = '0; signed_mode = 1'b0; blank_zeros = 1'b0;
    @(posedge Clk); #2;
    chk_en = 1'b1;
    repeat (2) @(posedge Clk);
    #2 Reset = 1'b0;
    @(negedge Clk);
    check32("reset_string", string_out, 32'h20202020);
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_load", int'(load_string), 0);

    convert("u1234",      14'd1234,  1'b0, 1'b0, 32'h31323334);
    convert("u7_nb",      14'd7,     1'b0, 1'b0, 32'h30303037);
    convert("u7_bz",      14'd7,     1'b0, 1'b1, 32'h20202037);
    convert("u0_bz",      14'd0,     1'b0, 1'b1, 32'h20202030);
    convert("sm12_bz",    14'h3FF4,  1'b1, 1'b1, 32'h202D3132);
    convert("sm12_nb",    14'h3FF4,  1'b1, 1'b0, 32'h2D303132);
    convert("sm999",      14'h3C19,  1'b1, 1'b0, 32'h2D393939);
    convert("u10000",     14'd10000, 1'b0, 1'b0, 32'h4F56464C);
    convert("sm1000",     14'h3C18,  1'b1, 1'b0, 32'h4F56464C);
    convert("sm8192",     14'h2000,  1'b1, 1'b1, 32'h4F56464C);
    convert("u9999",      14'd9999,  1'b0, 1'b1, 32'h39393939);
    convert("s8191",      14'h1FFF,  1'b1, 1'b0, 32'h38313931);
    convert("u16383",     14'h3FFF,  1'b0, 1'b0, 32'h4F56464C);
    convert("sm1_bz",     14'h3FFF,  1'b1, 1'b1, 32'h20202D31);
    convert("u8192_bz",   14'h2000,  1'b0, 1'b1, 32'h38313932);
    convert("u50_bz",     14'd50,    1'b0, 1'b1, 32'h20203530);
    convert("sm5_nb",     14'h3FFB,  1'b1, 1'b0, 32'h2D303035);
    convert("u305_bz",    14'd305,   1'b0, 1'b1, 32'h20333035);

    // start while busy is ignored
    @(posedge Clk); #2;
    value_in = 14'd42; signed_mode = 1'b0; blank_zeros = 1'b1; start = 1'b1;
    @(posedge Clk); #2 start = 1'b0;
    repeat (4) @(posedge Clk);
    #2 value_in = 14'd9876; blank_zeros = 1'b0; start = 1'b1;
    @(posedge Clk); #2 start = 1'b0;
    got = 0; i = 0;
    while (!got && i < 30) begin
      @(negedge Clk); i++;
      if (load_string) got = 1;
    end
    check_int("ignore_strobe_seen", int'(got), 1);
    check32("ignore_value", string_out, 32'h20203432);
    count_strobes(30, n);
    check_int("ignore_extra_strobes", n, 0);

    // start during the load_string cycle: results 16 cycles apart
    @(posedge Clk); #2;
    value_in = 14'd1111; signed_mode = 1'b0; blank_zeros = 1'b0; start = 1'b1;
    @(posedge Clk); #2 start = 1'b0;
    got = 0; i = 0;
    while (!got && i < 30) begin
      @(negedge Clk); i++;
      if (load_string) got = 1;
    end
    check_int("b2b_first_seen", int'(got), 1);
    check32("b2b_first", string_out, 32'h31313131);
    value_in = 14'd2222; start = 1'b1;
    @(posedge Clk); #2 start = 1'b0;
    got = 0; i = 0;
    while (!got && i < 30) begin
      @(negedge Clk); i++;
      if (load_string) got = 1;
    end
    check_int("b2b_second_seen", int'(got), 1);
    check_int("b2b_spacing", i, 16);
    check32("b2b_second", string_out, 32'h32323232);

    // Reset at step 7 aborts the conversion
    @(posedge Clk); #2;
    value_in = 14'd555; signed_mode = 1'b0; blank_zeros = 1'b0; start = 1'b1;
    @(posedge Clk); #2 start = 1'b0;
    repeat (6) @(posedge Clk);
    #2 Reset = 1'b1;
    @(posedge Clk); #2 Reset = 1'b0;
    @(negedge Clk);
    check_int("abort_busy", int'(busy), 0);
    check32("abort_string", string_out, 32'h20202020);
    count_strobes(25, n);
    check_int("abort_strobes", n, 0);

    // Reset wins over start in the same cycle
    @(posedge Clk); #2;
    value_in = 14'd1234; Reset = 1'b1; start = 1'b1;
    @(posedge Clk); #2 Reset = 1'b0; start = 1'b0;
    @(negedge Clk);
    check_int("rst_prio_busy", int'(busy), 0);
    count_strobes(20, n);
    check_int("rst_prio_strobes", n, 0);

    convert("after_reset", 14'd4321, 1'b0, 1'b0, 32'h34333231);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
